// File: rtl/rv32i_dmem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory controller (slave).
interface rv32i_dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_adr;
  logic [1:0]  req_sz;
  logic        req_us;
  logic [1:0]  req_type;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_adr, req_sz, req_us, req_type, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_adr, req_sz, req_us, req_type, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32i_dmem_ctrl.sv
// Load/store sequencer for a word-wide byte-enabled RAM; splits word-crossing accesses in two.
module rv32i_dmem_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32i_dmem_ctrl_if.slave      bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_W-1:0]     mem_adr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {StIdle, StAcc1, StAcc2, StCapt, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q;
  logic [1:0]          boff_q;
  logic [1:0]          sz_q;
  logic                us_q;
  logic                store_q;
  logic                err_q;
  logic [31:0]         wdata_q;
  logic [31:0]         lo_q;
  logic [31:0]         rdata_q;

  logic                req_illegal;
  logic                accept;
  logic                split;
  logic [3:0]          mask;
  logic [3:0]          be_lo, be_hi;
  logic [31:0]         wd_lo, wd_hi;
  logic [31:0]         lo_v, ld_sh, ld_res;

  logic unused_adr_bits;
  assign unused_adr_bits = ^bus.req_adr[31:ADDR_W+2];

  assign req_illegal = (bus.req_sz == 2'b11) ||
                       !((bus.req_type == 2'b01) || (bus.req_type == 2'b10));
  assign accept      = (state_q == StIdle) && bus.req_valid;

  // boff + nbytes > 4
  assign split = ((sz_q == 2'b01) && (boff_q == 2'd3)) ||
                 ((sz_q == 2'b10) && (boff_q != 2'd0));

  always_comb begin
    unique case (sz_q)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign be_lo = mask << boff_q;
  assign be_hi = mask >> (3'd4 - {1'b0, boff_q});
  assign wd_lo = wdata_q << {boff_q, 3'b000};
  assign wd_hi = wdata_q >> (6'd32 - {1'b0, boff_q, 3'b000});

  // Aligned loads take the low word straight from the RAM in CAPT.
  assign lo_v  = split ? lo_q : mem_rdata;
  assign ld_sh = 32'({mem_rdata, lo_v} >> {boff_q, 3'b000});

  always_comb begin
    unique case (sz_q)
      2'b00:   ld_res = {{24{~us_q & ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_res = {{16{~us_q & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_res = ld_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      adr_q   <= '0;
      boff_q  <= '0;
      sz_q    <= '0;
      us_q    <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        adr_q   <= bus.req_adr[ADDR_W+1:2];
        boff_q  <= bus.req_adr[1:0];
        sz_q    <= bus.req_sz;
        us_q    <= bus.req_us;
        store_q <= (bus.req_type == 2'b10);
        err_q   <= req_illegal;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if ((state_q == StAcc2) && !store_q) lo_q <= mem_rdata;
      if (state_q == StCapt) rdata_q <= ld_res;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.req_valid) state_d = req_illegal ? StResp : StAcc1;
      StAcc1: begin
        if (split)        state_d = StAcc2;
        else if (store_q) state_d = StResp;
        else              state_d = StCapt;
      end
      StAcc2:  state_d = store_q ? StResp : StCapt;
      StCapt:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and RAM strobes are gated by reset so a mid-operation reset issues no access.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_be        = 4'b0000;
    mem_adr       = '0;
    mem_wdata     = '0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: bus.req_ready = 1'b1;
        StAcc1: begin
          mem_en  = 1'b1;
          mem_we  = store_q;
          mem_adr = adr_q;
          if (store_q) begin
            mem_be    = be_lo;
            mem_wdata = wd_lo;
          end
        end
        StAcc2: begin
          mem_en  = 1'b1;
          mem_we  = store_q;
          mem_adr = adr_q + ADDR_W'(1);
          if (store_q) begin
            mem_be    = be_hi;
            mem_wdata = wd_hi;
          end
        end
        StResp: begin
          bus.rsp_valid = 1'b1;
          bus.rsp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_rdata = rdata_q;

endmodule

// File: doc/rv32i_dmem_ctrl.md
# rv32i_dmem_ctrl

Sequencer between the MEM stage and a single-port, word-wide, byte-enabled synchronous data RAM. It accepts one load/store request at a time over a valid/ready handshake. A misaligned access that crosses a word boundary is split into two aligned word accesses. Loads are reassembled and sign/zero-extended, and the result is returned as a single-cycle response pulse.

## Interface
- ADDR_W, default 8: RAM word-address width (2^ADDR_W words).
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_adr  in  32  byte address, little-endian.
- req_sz  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_us  in  1  load extension: 0 signed, 1 unsigned.
- req_type  in  2  access type: 01 load, 10 store, other values illegal.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse. No backpressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; high when the request was illegal.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  RAM write.
- mem_be  out  4  byte enables; 0000 on reads.
- mem_adr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after a read with mem_en=1.

## Operation
States:
- IDLE: req_ready=1. On req_valid, the request fields are latched and the controller moves to ACC1. An illegal req_sz or req_type goes straight to RESP with rsp_err=1.
- ACC1: mem_en=1, mem_adr = boff-word A = req_adr[ADDR_W+1:2] (upper address bits ignored).
  - Moves to ACC2 if split, else CAPT for a load, else RESP for a store.
- ACC2: mem_en=1, mem_adr = A+1 mod 2^ADDR_W.
  - A load latches mem_rdata (word A) into lo; then CAPT.
  - A store goes to RESP.
- CAPT (loads only): no memory access. Assembles the result from {hi, lo} and registers it into rsp_rdata; then RESP.
  - Aligned load: lo = mem_rdata and hi is unused.
  - Split load: hi = mem_rdata.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.

Access rules:
- boff = req_adr[1:0]; nbytes = 1, 2 or 4.
- Split when boff + nbytes > 4: half at boff 3, word at boff 1, 2 or 3.
- Load result = ({hi, lo} >> 8·boff) truncated to nbytes, then extended per req_us. Word loads ignore req_us.
- Store masks: m = 0001/0011/1111 for byte/half/word.
  - First word: mem_be = (m << boff)[3:0], mem_wdata = req_wdata << 8·boff.
  - Second word: mem_be = m >> (4 − boff), mem_wdata = req_wdata >> 8·(4 − boff).
- Request inputs are sampled only at accept; later changes are ignored.
- req_ready=0 in every state except IDLE. One request is outstanding at most.

## Timing
Let T be the accept cycle. rsp_valid is high in:
- T+1 for an illegal request;
- T+2 for an aligned store;
- T+3 for a split store or an aligned load;
- T+4 for a split load.

Next accept is possible no earlier than the cycle after RESP.

Reset:
- While rst_n=0, req_ready, rsp_valid, rsp_err, mem_en and mem_we are forced to 0. The state becomes IDLE at the clock edge.
- rsp_rdata, mem_be, mem_adr and mem_wdata reset to 0.
- Reset mid-operation aborts the request with no response and no further RAM access. In a split store, word A may already have been written; this is accepted.

Address wrap: word 2^ADDR_W−1 followed by word 0 is legal and gives no error.

## Test plan
- Aligned LW at 0x10, with RAM[4]=0xDEADBEEF -> one mem_en (adr 4, mem_we=0), rsp_rdata=0xDEADBEEF at T+3, rsp_err=0.
- LH at 0x13, with RAM[4]=0xAB000000 and RAM[5]=0x000000FF:
  - RAM accesses to adr 4 then adr 5;
  - req_us=0 -> 0xFFFFFFAB at T+4;
  - req_us=1 -> 0x0000FFAB.
- SW 0x11223344 at 0x22 -> ACC1 adr 8, be 1100, wdata 0x33440000; ACC2 adr 9, be 0011, wdata 0x00001122; rsp_valid at T+3, rsp_rdata=0.
- Wrap and byte store:
  - SB 0xA5 at 0x3FF -> single write, adr 255, be 1000, wdata 0xA5000000;
  - SW at 0x3FE -> writes adr 255 (be 1100), then adr 0 (be 0011).
- Illegal requests:
  - req_sz=11 -> no mem_en, rsp_valid with rsp_err=1 and rsp_rdata=0 at T+1;
  - req_type=00 -> same response;
  - req_ready stays 0 from T+1 until the cycle after RESP.
- Reset mid-operation: rst_n=0 during ACC2 of a split store -> mem_en=0 that cycle, no rsp_valid, IDLE with req_ready=1 once rst_n=1; a back-to-back LW then completes normally.
